wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage LoongArch pipeline, directly downstream of the memory stage. Holds the final pipeline register, commits GPR writes, and forwards results to decode. Prioritises exceptions and `ertn`, drives the CSR-side exception interface, and raises `ws_block` to kill younger instructions. Also owns the 64-bit stable counter read by `rdcntvl`/`rdcntvh`.

## Interface

Parameters:
- `CNT_INIT`, default `64'd0`: stable counter value after reset.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: reset; asynchronous, active-low.
- `ms_to_ws_valid` in 1: upstream valid, already gated by `ws_block` upstream.
- `ms_to_ws_bus` in `MS_TO_WS_BUS_WD` (189): fields, MSB first:
  - `rdcntid`[188], `has_int`[187], `ine`[186], `ale`[185], `brk`[184]
  - `vaddr`[183:152], `adef`[151], `ertn`[150], `sys`[149]
  - `csr_num`[148:135], `csr_we`[134], `csr_wdata`[133:102], `csr_wmask`[101:70]
  - `gr_we`[69], `dest`[68:64], `final_result`[63:32], `pc`[31:0]
- `ws_allowin` out 1: stage can accept an instruction.
- `ws_block` out 1: kill window for younger instructions.
- `ws_to_rf_bus` out 38: `{we, waddr[4:0], wdata[31:0]}`.
- `ws_to_ds_bus` out 54: `{rdcntid&valid, csr_we&valid, csr_num, we, dest, wdata}`; same layout as the memory-stage forward bus.
- `csr_we`, `csr_num[13:0]`, `csr_wdata[31:0]`, `csr_wmask[31:0]` out: CSR write port.
- `csr_tid` in 32: TID CSR value.
- `wb_ex` out 1: exception commit pulse.
- `wb_ecode` out 6, `wb_esubcode` out 9, `wb_pc` out 32, `wb_vaddr` out 32: exception details.
- `ertn_flush` out 1: `ertn` commit pulse.
- `cnt_value` out 64: stable counter value.
- `debug_wb_pc` out 32, `debug_wb_rf_we` out 4, `debug_wb_rf_wnum` out 5, `debug_wb_rf_wdata` out 32: trace outputs.

## Operation

- Pipeline register:
  - `ws_ready_go` = 1.
  - `ws_allowin` = `!ws_valid || ws_ready_go`.
  - When `ws_allowin` is high, `ws_valid` loads `ms_to_ws_valid`.
  - The bus register loads only on `ms_to_ws_valid && ws_allowin`.
- Exception priority (highest first), with code/subcode:
  - `has_int`: 0x00 / 0
  - `adef`: 0x08 / 0
  - `ine`: 0x0D / 0
  - `sys`: 0x0B / 0
  - `brk`: 0x0C / 0
  - `ale`: 0x09 / 0
- `wb_ex` = `ws_valid` && any of the six flags.
- `wb_vaddr` = `pc` for `adef`, `vaddr` for `ale`, otherwise 0.
- `wb_pc` = `pc`.
- `ertn_flush` = `ws_valid && ertn && !wb_ex`.
- GPR write:
  - `we` = `ws_valid && gr_we && !wb_ex && !ertn`.
  - `wdata` = `csr_tid` if `rdcntid`, else `final_result`.
  - A write to r0 is passed through unchanged; the regfile ignores it.
- CSR write: `csr_we` = `ws_valid && csr_we_field && !wb_ex`.
- Debug trace:
  - `debug_wb_rf_we` = `{4{we}}`.
  - `debug_wb_pc` = `pc`.
  - `debug_wb_rf_wnum` = `dest`; `debug_wb_rf_wdata` = `wdata`.
- `ws_block` = `(wb_ex | ertn_flush) | block_q`.
  - `block_q` is a register set to `wb_ex | ertn_flush` each cycle.
  - The kill window is therefore the commit cycle plus one.
- Stable counter: increments by 1 every cycle and wraps from 2^64−1 to 0. It is not stalled by pipeline state.

## Timing

- Reset (async assert, `reset`=0):
  - `ws_valid`=0, `block_q`=0, `cnt_value`=`CNT_INIT`.
  - All outputs derived from `ws_valid` read 0.
  - `ws_allowin`=1.
- Reset deasserts synchronously to `clk` via the register-enable path; no output glitch is permitted.
- Reset mid-commit: the pending instruction is dropped and no write occurs after reset asserts.
- Latency: an instruction accepted at edge N commits (rf/CSR write, `wb_ex`) combinationally during cycle N. The regfile/CSR samples at edge N+1.
- `wb_ex` and `ertn_flush` are single-cycle pulses per instruction.
- Two back-to-back exception instructions cannot both commit: the second is killed upstream by `ws_block`.
- Simultaneous `ertn` and an exception flag: exception wins, `ertn_flush`=0.
- Simultaneous `rdcntid` and exception: no GPR write.

## Structure

- `mycpu.h` gains:
  - `WS_TO_RF_BUS_WD` (38) and `WS_TO_DS_BUS_WD` (54).
  - `ECODE_INT`, `ECODE_ADEF`, `ECODE_ALE`, `ECODE_SYS`, `ECODE_BRK`, `ECODE_INE`.
- One sub-module, `stable_counter`: 64-bit free-running counter with async active-low reset and parameter `INIT`.

## Test plan

- Reset held low 3 cycles, then released → `ws_allowin`=1, `ws_to_rf_bus`=0, `cnt_value`=0 then 1, 2, ….
- Valid bus with `gr_we`=1, `dest`=5, `final_result`=0x1234_5678, `pc`=0x1C00_0000 → rf write r5=0x12345678 next edge; `debug_wb_rf_we`=4'hF.
- `sys`=1 and `gr_we`=1, `pc`=0x1C00_0010 → `wb_ex`=1, `wb_ecode`=0x0B, no rf write, `ws_block` high 2 cycles.
- `has_int`=1 and `ine`=1 → `wb_ecode`=0x00; `ale`=1 with `vaddr`=0x8000_0003 alone → `wb_ecode`=0x09, `wb_vaddr`=0x80000003.
- `ertn`=1 → `ertn_flush` single-cycle pulse; `ertn` with `brk` → `wb_ecode`=0x0C, `ertn_flush`=0.
- `CNT_INIT`=64'hFFFF_FFFF_FFFF_FFFE → counter reads …FE, …FF, 0 on successive cycles; `rdcntid` with `csr_tid`=7 writes 7 to `dest`.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared widths, exception codes and the memory-to-writeback bus layout
// for the write-back stage.
package wb_stage_pkg;

    localparam int MS_TO_WS_BUS_WD = 189;
    localparam int WS_TO_RF_BUS_WD = 38;
    localparam int WS_TO_DS_BUS_WD = 54;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // Field order is MSB first and must match the memory stage packing.
    typedef struct packed {
        logic        rdcntid;
        logic        has_int;
        logic        ine;
        logic        ale;
        logic        brk;
        logic [31:0] vaddr;
        logic        adef;
        logic        ertn;
        logic        sys;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wdata;
        logic [31:0] csr_wmask;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_bus_t;

    // True when the instruction carries any exception flag.
    function automatic logic has_exc(input ms_to_ws_bus_t b);
        return b.has_int | b.adef | b.ine | b.sys | b.brk | b.ale;
    endfunction

    // Exception code of the highest-priority flag; 0 when none is set.
    function automatic logic [5:0] exc_ecode(input ms_to_ws_bus_t b);
        if (b.has_int)   return ECODE_INT;
        else if (b.adef) return ECODE_ADEF;
        else if (b.ine)  return ECODE_INE;
        else if (b.sys)  return ECODE_SYS;
        else if (b.brk)  return ECODE_BRK;
        else if (b.ale)  return ECODE_ALE;
        else             return 6'h00;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage to write-back-stage link.
// Handshake: an instruction moves when ms_to_ws_valid && ws_allowin are both
// high at a rising clk edge; the sender holds bus stable while valid is high.
// ws_block flows back so the sender can suppress younger instructions.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       ws_allowin;
    logic                       ws_block;

    modport master (output ms_to_ws_valid, ms_to_ws_bus, input ws_allowin, ws_block);
    modport slave  (input ms_to_ws_valid, ms_to_ws_bus, output ws_allowin, ws_block);
endinterface

// File: rtl/wb_stage_stable_counter.sv
// 64-bit free-running stable counter, wraps naturally at 2^64-1.
module stable_counter #(
    parameter logic [63:0] INIT = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] cnt_value
);

    // Count every cycle regardless of pipeline state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_value <= INIT;
        else        cnt_value <= cnt_value + 64'd1;
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: final pipeline register, GPR/CSR commit, exception and
// ertn reporting, kill window for younger instructions, stable counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [63:0] CNT_INIT = 64'd0
) (
    input  logic                       clk,
    input  logic                       reset,
    wb_stage_if.slave                  ms,
    output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
    output logic [WS_TO_DS_BUS_WD-1:0] ws_to_ds_bus,
    output logic                       csr_we,
    output logic [13:0]                csr_num,
    output logic [31:0]                csr_wdata,
    output logic [31:0]                csr_wmask,
    input  logic [31:0]                csr_tid,
    output logic                       wb_ex,
    output logic [5:0]                 wb_ecode,
    output logic [8:0]                 wb_esubcode,
    output logic [31:0]                wb_pc,
    output logic [31:0]                wb_vaddr,
    output logic                       ertn_flush,
    output logic [63:0]                cnt_value,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_we,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    logic          ws_valid;
    logic          ws_ready_go;
    logic          block_q;
    ms_to_ws_bus_t ws_bus;
    logic          rf_we;
    logic [31:0]   rf_wdata;
    logic          commit_kill;

    assign ws_ready_go   = 1'b1;
    assign ms.ws_allowin = !ws_valid || ws_ready_go;

    // Stage occupancy; reset drops any pending instruction immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             ws_valid <= 1'b0;
        else if (ms.ws_allowin) ws_valid <= ms.ms_to_ws_valid;
    end

    // Payload register, loaded only on an accepted transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                ws_bus <= '0;
        else if (ms.ms_to_ws_valid && ms.ws_allowin) ws_bus <= ms.ms_to_ws_bus;
    end

    // Exceptions outrank ertn; both suppress the GPR write.
    assign wb_ex       = ws_valid && has_exc(ws_bus);
    assign wb_ecode    = wb_ex ? exc_ecode(ws_bus) : 6'h00;
    assign wb_esubcode = 9'd0;
    assign wb_pc       = ws_bus.pc;
    assign wb_vaddr    = ws_bus.adef ? ws_bus.pc : (ws_bus.ale ? ws_bus.vaddr : 32'd0);
    assign ertn_flush  = ws_valid && ws_bus.ertn && !wb_ex;

    assign rf_we    = ws_valid && ws_bus.gr_we && !wb_ex && !ws_bus.ertn;
    assign rf_wdata = ws_bus.rdcntid ? csr_tid : ws_bus.final_result;

    assign ws_to_rf_bus = {rf_we, ws_bus.dest, rf_wdata};
    assign ws_to_ds_bus = {ws_bus.rdcntid & ws_valid, ws_bus.csr_we & ws_valid,
                           ws_bus.csr_num, rf_we, ws_bus.dest, rf_wdata};

    assign csr_we    = ws_valid && ws_bus.csr_we && !wb_ex;
    assign csr_num   = ws_bus.csr_num;
    assign csr_wdata = ws_bus.csr_wdata;
    assign csr_wmask = ws_bus.csr_wmask;

    assign debug_wb_pc       = ws_bus.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_bus.dest;
    assign debug_wb_rf_wdata = rf_wdata;

    // Kill window covers the commit cycle and the one after it.
    assign commit_kill = wb_ex | ertn_flush;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) block_q <= 1'b0;
        else        block_q <= commit_kill;
    end
    assign ms.ws_block = commit_kill | block_q;

    stable_counter #(.INIT(CNT_INIT)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .cnt_value (cnt_value)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized
// instructions scored against a rule-level reference model.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam logic [63:0] CNT_INIT2 = 64'hFFFF_FFFF_FFFF_FFFE;

    typedef struct packed {
        logic        ex;
        logic [5:0]  ecode;
        logic [31:0] vaddr;
        logic        ertn_flush;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_we;
    } exp_t;

    logic clk;
    logic reset;
    logic [31:0] csr_tid;

    wb_stage_if dif ();
    wb_stage_if dif2 ();

    logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus, ws_to_rf_bus2;
    logic [WS_TO_DS_BUS_WD-1:0] ws_to_ds_bus, ws_to_ds_bus2;
    logic        csr_we, csr_we2;
    logic [13:0] csr_num, csr_num2;
    logic [31:0] csr_wdata, csr_wdata2, csr_wmask, csr_wmask2;
    logic        wb_ex, wb_ex2;
    logic [5:0]  wb_ecode, wb_ecode2;
    logic [8:0]  wb_esubcode, wb_esubcode2;
    logic [31:0] wb_pc, wb_pc2, wb_vaddr, wb_vaddr2;
    logic        ertn_flush, ertn_flush2;
    logic [63:0] cnt_value, cnt_value2;
    logic [31:0] debug_wb_pc, debug_wb_pc2;
    logic [3:0]  debug_wb_rf_we, debug_wb_rf_we2;
    logic [4:0]  debug_wb_rf_wnum, debug_wb_rf_wnum2;
    logic [31:0] debug_wb_rf_wdata, debug_wb_rf_wdata2;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] cyc;
    exp_t exp_q[$];
    ms_to_ws_bus_t bus_q[$];

    wb_stage dut (
        .clk(clk), .reset(reset), .ms(dif.slave),
        .ws_to_rf_bus(ws_to_rf_bus), .ws_to_ds_bus(ws_to_ds_bus),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
        .csr_tid(csr_tid), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .cnt_value(cnt_value),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    wb_stage #(.CNT_INIT(CNT_INIT2)) dut2 (
        .clk(clk), .reset(reset), .ms(dif2.slave),
        .ws_to_rf_bus(ws_to_rf_bus2), .ws_to_ds_bus(ws_to_ds_bus2),
        .csr_we(csr_we2), .csr_num(csr_num2), .csr_wdata(csr_wdata2), .csr_wmask(csr_wmask2),
        .csr_tid(csr_tid), .wb_ex(wb_ex2), .wb_ecode(wb_ecode2), .wb_esubcode(wb_esubcode2),
        .wb_pc(wb_pc2), .wb_vaddr(wb_vaddr2), .ertn_flush(ertn_flush2), .cnt_value(cnt_value2),
        .debug_wb_pc(debug_wb_pc2), .debug_wb_rf_we(debug_wb_rf_we2),
        .debug_wb_rf_wnum(debug_wb_rf_wnum2), .debug_wb_rf_wdata(debug_wb_rf_wdata2)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release, the counter reference.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 64'd0;
        else        cyc <= cyc + 64'd1;
    end

    // Reference: exception is the first set flag in the priority list.
    function automatic exp_t model(input ms_to_ws_bus_t b, input logic [31:0] tid);
        exp_t e;
        logic [5:0] flags;
        int codes[6];
        codes = '{0, 8, 13, 11, 12, 9};
        flags = {b.has_int, b.adef, b.ine, b.sys, b.brk, b.ale};
        e = '0;
        for (int i = 0; i < 6; i++)
            if (flags[5-i] && !e.ex) begin
                e.ex = 1'b1;
                e.ecode = 6'(codes[i]);
            end
        e.vaddr = b.adef ? b.pc : (b.ale ? b.vaddr : 32'd0);
        e.ertn_flush = b.ertn && !e.ex;
        e.rf_we = b.gr_we && !e.ex && !b.ertn;
        e.waddr = b.dest;
        e.wdata = b.rdcntid ? tid : b.final_result;
        e.csr_we = b.csr_we && !e.ex;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.ex = wb_ex;
        o.ecode = wb_ecode;
        o.vaddr = wb_vaddr;
        o.ertn_flush = ertn_flush;
        o.rf_we = ws_to_rf_bus[37];
        o.waddr = ws_to_rf_bus[36:32];
        o.wdata = ws_to_rf_bus[31:0];
        o.csr_we = csr_we;
        return o;
    endfunction

    // Driver: present one instruction for one cycle; returns #1 after acceptance.
    task automatic send(input ms_to_ws_bus_t b, input logic [31:0] tid);
        @(negedge clk);
        dif.ms_to_ws_valid = 1'b1;
        dif.ms_to_ws_bus = b;
        csr_tid = tid;
        @(posedge clk);
        #1;
        dif.ms_to_ws_valid = 1'b0;
        exp_q.push_back(model(b, tid));
        bus_q.push_back(b);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({dif.ws_allowin, ws_to_rf_bus, wb_ex, ertn_flush, dif.ws_block, csr_we} !== {1'b1, 38'd0, 4'd0}) begin
            $display("FAIL reset_outputs: got allowin=%b rf=%h ex=%b ertn=%b block=%b csr_we=%b",
                     dif.ws_allowin, ws_to_rf_bus, wb_ex, ertn_flush, dif.ws_block, csr_we);
        end else pass_cnt++;
        total_cnt++;
        if (cnt_value !== 64'd0 || cnt_value2 !== CNT_INIT2) begin
            $display("FAIL reset_cnt: got %h / %h want 0 / %h", cnt_value, cnt_value2, CNT_INIT2);
        end else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (cnt_value !== 64'(k) || cnt_value2 !== CNT_INIT2 + 64'(k)) begin
                $display("FAIL cnt_step%0d: got %h / %h want %h / %h", k, cnt_value, cnt_value2,
                         64'(k), CNT_INIT2 + 64'(k));
            end else pass_cnt++;
        end
    endtask

    task automatic test_gpr_write();
        ms_to_ws_bus_t b;
        b = '0;
        b.gr_we = 1'b1; b.dest = 5'd5; b.final_result = 32'h1234_5678; b.pc = 32'h1C00_0000;
        send(b, 32'd0);
        void'(exp_q.pop_front()); void'(bus_q.pop_front());
        total_cnt++;
        if (ws_to_rf_bus !== {1'b1, 5'd5, 32'h1234_5678} || debug_wb_rf_we !== 4'hF ||
            debug_wb_pc !== 32'h1C00_0000 || wb_ex !== 1'b0) begin
            $display("FAIL gpr_write: got rf=%h dbg_we=%h pc=%h ex=%b want rf=%h dbg_we=f pc=1c000000 ex=0",
                     ws_to_rf_bus, debug_wb_rf_we, debug_wb_pc, wb_ex, {1'b1, 5'd5, 32'h1234_5678});
        end else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (ws_to_rf_bus[37] !== 1'b0) begin
            $display("FAIL gpr_single_write: got we=%b want 0", ws_to_rf_bus[37]);
        end else pass_cnt++;
    endtask

    task automatic test_sys_block();
        ms_to_ws_bus_t b;
        b = '0;
        b.sys = 1'b1; b.gr_we = 1'b1; b.dest = 5'd3; b.pc = 32'h1C00_0010;
        send(b, 32'd0);
        void'(exp_q.pop_front()); void'(bus_q.pop_front());
        total_cnt++;
        if ({wb_ex, wb_ecode, wb_esubcode, ws_to_rf_bus[37], wb_pc, dif.ws_block} !==
            {1'b1, 6'h0B, 9'd0, 1'b0, 32'h1C00_0010, 1'b1}) begin
            $display("FAIL sys_commit: got ex=%b ecode=%h sub=%h we=%b pc=%h block=%b want 1 0b 0 0 1c000010 1",
                     wb_ex, wb_ecode, wb_esubcode, ws_to_rf_bus[37], wb_pc, dif.ws_block);
        end else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (dif.ws_block !== 1'b1 || wb_ex !== 1'b0) begin
            $display("FAIL sys_block2: got block=%b ex=%b want 1 0", dif.ws_block, wb_ex);
        end else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (dif.ws_block !== 1'b0) begin
            $display("FAIL sys_block3: got block=%b want 0", dif.ws_block);
        end else pass_cnt++;
    endtask

    task automatic test_priority();
        ms_to_ws_bus_t b;
        b = '0;
        b.has_int = 1'b1; b.ine = 1'b1; b.pc = 32'h1C00_0020;
        send(b, 32'd0);
        void'(exp_q.pop_front()); void'(bus_q.pop_front());
        total_cnt++;
        if (wb_ex !== 1'b1 || wb_ecode !== 6'h00 || wb_vaddr !== 32'd0) begin
            $display("FAIL int_over_ine: got ex=%b ecode=%h vaddr=%h want 1 00 0", wb_ex, wb_ecode, wb_vaddr);
        end else pass_cnt++;
        repeat (2) @(posedge clk);
        b = '0;
        b.ale = 1'b1; b.vaddr = 32'h8000_0003; b.pc = 32'h1C00_0024;
        send(b, 32'd0);
        void'(exp_q.pop_front()); void'(bus_q.pop_front());
        total_cnt++;
        if (wb_ex !== 1'b1 || wb_ecode !== 6'h09 || wb_vaddr !== 32'h8000_0003) begin
            $display("FAIL ale: got ex=%b ecode=%h vaddr=%h want 1 09 80000003", wb_ex, wb_ecode, wb_vaddr);
        end else pass_cnt++;
        repeat (2) @(posedge clk);
        b = '0;
        b.adef = 1'b1; b.ale = 1'b1; b.vaddr = 32'h1111_2222; b.pc = 32'h1C00_0031;
        send(b, 32'd0);
        void'(exp_q.pop_front()); void'(bus_q.pop_front());
        total_cnt++;
        if (wb_ecode !== 6'h08 || wb_vaddr !== 32'h1C00_0031) begin
            $display("FAIL adef: got ecode=%h vaddr=%h want 08 1c000031", wb_ecode, wb_vaddr);
        end else pass_cnt++;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ertn();
        ms_to_ws_bus_t b;
        b = '0;
        b.ertn = 1'b1; b.gr_we = 1'b1; b.pc = 32'h1C00_0040;
        send(b, 32'd0);
        void'(exp_q.pop_front()); void'(bus_q.pop_front());
        total_cnt++;
        if (ertn_flush !== 1'b1 || wb_ex !== 1'b0 || ws_to_rf_bus[37] !== 1'b0 || dif.ws_block !== 1'b1) begin
            $display("FAIL ertn_commit: got flush=%b ex=%b we=%b block=%b want 1 0 0 1",
                     ertn_flush, wb_ex, ws_to_rf_bus[37], dif.ws_block);
        end else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (ertn_flush !== 1'b0 || dif.ws_block !== 1'b1) begin
            $display("FAIL ertn_pulse: got flush=%b block=%b want 0 1", ertn_flush, dif.ws_block);
        end else pass_cnt++;
        @(posedge clk);
        b = '0;
        b.ertn = 1'b1; b.brk = 1'b1; b.pc = 32'h1C00_0044;
        send(b, 32'd0);
        void'(exp_q.pop_front()); void'(bus_q.pop_front());
        total_cnt++;
        if (wb_ex !== 1'b1 || wb_ecode !== 6'h0C || ertn_flush !== 1'b0) begin
            $display("FAIL ertn_brk: got ex=%b ecode=%h flush=%b want 1 0c 0", wb_ex, wb_ecode, ertn_flush);
        end else pass_cnt++;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_rdcntid();
        ms_to_ws_bus_t b;
        b = '0;
        b.rdcntid = 1'b1; b.gr_we = 1'b1; b.dest = 5'd9; b.final_result = 32'hDEAD_BEEF;
        send(b, 32'd7);
        void'(exp_q.pop_front()); void'(bus_q.pop_front());
        total_cnt++;
        if (ws_to_rf_bus !== {1'b1, 5'd9, 32'd7} || ws_to_ds_bus[53] !== 1'b1) begin
            $display("FAIL rdcntid: got rf=%h ds_rdcnt=%b want %h 1", ws_to_rf_bus, ws_to_ds_bus[53],
                     {1'b1, 5'd9, 32'd7});
        end else pass_cnt++;
        b.ine = 1'b1;
        send(b, 32'd7);
        void'(exp_q.pop_front()); void'(bus_q.pop_front());
        total_cnt++;
        if (ws_to_rf_bus[37] !== 1'b0 || wb_ecode !== 6'h0D) begin
            $display("FAIL rdcntid_ex: got we=%b ecode=%h want 0 0d", ws_to_rf_bus[37], wb_ecode);
        end else pass_cnt++;
        repeat (2) @(posedge clk);
    endtask

    // Upstream role: a younger exception held back while ws_block is high.
    task automatic test_back_to_back();
        ms_to_ws_bus_t b;
        b = '0;
        b.brk = 1'b1; b.pc = 32'h1C00_0050;
        send(b, 32'd0);
        void'(exp_q.pop_front()); void'(bus_q.pop_front());
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            b.pc = 32'h1C00_0054;
            dif.ms_to_ws_bus = b;
            dif.ms_to_ws_valid = !dif.ws_block;
            @(posedge clk);
            #1;
            dif.ms_to_ws_valid = 1'b0;
            total_cnt++;
            if (wb_ex !== 1'b0) begin
                $display("FAIL b2b_killed%0d: got ex=%b want 0", k, wb_ex);
            end else pass_cnt++;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid_commit();
        ms_to_ws_bus_t b;
        b = '0;
        b.gr_we = 1'b1; b.csr_we = 1'b1; b.dest = 5'd4; b.final_result = 32'hCAFE_0001;
        send(b, 32'd0);
        void'(exp_q.pop_front()); void'(bus_q.pop_front());
        reset = 1'b0;
        #1;
        total_cnt++;
        if (ws_to_rf_bus[37] !== 1'b0 || csr_we !== 1'b0 || debug_wb_rf_we !== 4'h0 || cnt_value !== 64'd0) begin
            $display("FAIL reset_mid_commit: got we=%b csr_we=%b dbg=%h cnt=%h want 0 0 0 0",
                     ws_to_rf_bus[37], csr_we, debug_wb_rf_we, cnt_value);
        end else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        ms_to_ws_bus_t b;
        ms_to_ws_bus_t bq;
        exp_t e;
        exp_t o;
        logic [31:0] tid;
        for (int n = 0; n < 300; n++) begin
            b = '0;
            b.rdcntid = ($urandom_range(0, 5) == 0);
            b.has_int = ($urandom_range(0, 9) == 0);
            b.ine = ($urandom_range(0, 9) == 0);
            b.ale = ($urandom_range(0, 9) == 0);
            b.brk = ($urandom_range(0, 9) == 0);
            b.adef = ($urandom_range(0, 9) == 0);
            b.ertn = ($urandom_range(0, 7) == 0);
            b.sys = ($urandom_range(0, 9) == 0);
            b.vaddr = $urandom;
            b.csr_num = 14'($urandom);
            b.csr_we = $urandom_range(0, 1);
            b.csr_wdata = $urandom;
            b.csr_wmask = $urandom;
            b.gr_we = $urandom_range(0, 1);
            b.dest = 5'($urandom);
            b.final_result = $urandom;
            b.pc = $urandom;
            tid = $urandom;
            send(b, tid);
            e = exp_q.pop_front();
            bq = bus_q.pop_front();
            o = observe();
            total_cnt++;
            if (o !== e) begin
                $display("FAIL rand%0d_commit: got %h want %h", n, o, e);
            end else pass_cnt++;
            total_cnt++;
            if ({csr_num, csr_wdata, csr_wmask, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
                 ws_to_ds_bus, cnt_value} !==
                {bq.csr_num, bq.csr_wdata, bq.csr_wmask, bq.pc, {4{e.rf_we}}, bq.dest, e.wdata,
                 {bq.rdcntid, bq.csr_we, bq.csr_num, e.rf_we, bq.dest, e.wdata}, cyc}) begin
                $display("FAIL rand%0d_side: csr=%h/%h/%h pc=%h dbg=%h/%h/%h ds=%h cnt=%h exp cnt=%h",
                         n, csr_num, csr_wdata, csr_wmask, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum,
                         debug_wb_rf_wdata, ws_to_ds_bus, cnt_value, cyc);
            end else pass_cnt++;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
                total_cnt++;
                if ({wb_ex, ertn_flush, ws_to_rf_bus[37], csr_we} !== 4'b0000) begin
                    $display("FAIL rand%0d_idle: got ex=%b flush=%b we=%b csr_we=%b want 0000",
                             n, wb_ex, ertn_flush, ws_to_rf_bus[37], csr_we);
                end else pass_cnt++;
            end
        end
    endtask

    initial begin
        dif.ms_to_ws_valid = 1'b0;
        dif.ms_to_ws_bus = '0;
        dif2.ms_to_ws_valid = 1'b0;
        dif2.ms_to_ws_bus = '0;
        csr_tid = 32'd0;
        test_reset();
        test_gpr_write();
        test_sys_block();
        test_priority();
        test_ertn();
        test_rdcntid();
        test_back_to_back();
        test_reset_mid_commit();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
